hud_cell_strip: RTL
===================

Name: hud_cell_strip

Overview:
Parametrised HUD strip object that draws a row or column of N identical cells (hearts, digits, fuel pips) and gives each pixel its cell index and in-cell offset. It adds three behaviours: per-frame latching of position, animated count changes (one cell per step) and a retriggerable blink on a flash event. It sits between the VGA pixel counters and the bitmap ROM / drawing mux, in the same slot as the single-rectangle object.

Parameters:
CELL_W, 16, cell width in pixels
CELL_H, 16, cell height in pixels
GAP, 0, pixels between adjacent cells
NUM_CELLS, 6, maximum cells (1..15)
IDX_W, 3, width of cellIndex; must satisfy 2**IDX_W >= NUM_CELLS
VERTICAL, 0, 0 = cells laid along X, 1 = along Y
INIT_COUNT, 3, shownCount after reset
STEP_FRAMES, 4, frames per one-cell count change
BLINK_FRAMES, 8, frames per blink half-period
BLINK_REPEATS, 3, off/on pairs per flash

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
enable  in  1  0 = no drawing, all timers frozen
startOfFrame  in  1  one-cycle pulse per frame
pixelX  in  11 signed  current pixel X
pixelY  in  11 signed  current pixel Y
topLeftX  in  11 signed  strip origin X
topLeftY  in  11 signed  strip origin Y
targetCount  in  4  requested visible cells
flash  in  1  one-cycle pulse that starts or retriggers blink
drawingRequest  out  1  pixel is inside a visible cell
cellIndex  out  IDX_W  index of the hit cell (0 = nearest origin)
offsetX  out  11  pixel X minus cell left edge
offsetY  out  11  pixel Y minus cell top edge
shownCount  out  4  number of cells currently displayed
busy  out  1  count animating or blink active

Behaviour:
- Reset values: drawingRequest=0, cellIndex=0, offsetX=0, offsetY=0, shownCount=INIT_COUNT, busy=0. Blink FSM goes to IDLE, all counters clear, latched origin = (0,0).
- Origin latch: on startOfFrame, tlX_q/tlY_q <= topLeftX/topLeftY. Hit-testing uses only the latched values, so a mid-frame move does not tear.
- Clamp: tgt = min(targetCount, NUM_CELLS).
- Count animation: frame counter stepCnt counts startOfFrame pulses. When stepCnt reaches STEP_FRAMES-1 it wraps to 0 and shownCount moves one unit toward tgt. When shownCount == tgt, stepCnt is held at 0.
- Blink FSM, states IDLE / OFF / ON:
  - IDLE + flash -> OFF. halfCnt=0, repCnt=0.
  - OFF: after BLINK_FRAMES frame ticks -> ON.
  - ON: after BLINK_FRAMES frame ticks, repCnt++; if repCnt == BLINK_REPEATS-1 -> IDLE, else -> OFF.
  - flash in OFF or ON -> OFF with counters reloaded (retrigger).
  - flash and startOfFrame in the same cycle: flash wins, and that tick is not counted.
- busy = (shownCount != tgt) || (state != IDLE).
- Hit test (along the layout axis; for VERTICAL=1 swap the X and Y roles):
  - pitch = CELL_W+GAP. rel = pixel - tl_q.
  - Cell k is hit when k < shownCount, k*pitch <= relMain < k*pitch+CELL_W, and 0 <= relCross < CELL_H.
  - Implement as a generate comparator loop over NUM_CELLS; no divider.
  - Pixels in a GAP or in cells >= shownCount are not hits.
- Output stage (registered, latency 1 clk from pixelX/pixelY):
  - On a hit with state != OFF and enable=1: drawingRequest=1, cellIndex=k, offsetX/offsetY = offsets from cell k's top-left.
  - Otherwise: drawingRequest=0, cellIndex=0, offsets=0.
- enable=0: outputs forced to their non-hit values. stepCnt, halfCnt and FSM hold; the origin latch still updates.
- Negative rel values (pixel left of or above the origin) are never hits. Signed 12-bit compare avoids wrap.
- shownCount=0: the strip is invisible. Blink still runs if triggered.
- Reset mid-animation or mid-blink: immediate return to reset values on the next clk edge.

Decomposition:
- Package hud_pkg:
  - blink_state_t enum {BLINK_IDLE, BLINK_OFF, BLINK_ON}.
  - Constant PIX_W=11.
  - Function clamp_count(target, max).
- Sub-module hud_blink_fsm (clk, reset, enable, frameTick, flash -> blankN, active), holding the FSM and its counters. The top level keeps the origin latch, count animation and hit test.

Test Plan:
- Reset, defaults, origin (100,50), startOfFrame once, pixel (100..195,50) -> drawingRequest=1 only for X 100..147 (3 cells), cellIndex 0/1/2 at X=100/116/132, offsetX 0..15, output 1 clk after pixel.
- GAP=4, pixel X=116..119 -> drawingRequest=0; X=120 -> cellIndex=1, offsetX=0.
- targetCount=6 from 3, STEP_FRAMES=4 -> shownCount 4,5,6 after frames 4,8,12; busy=1 until frame 12. targetCount=9 -> settles at 6.
- flash pulse -> strip blank frames 0-7, visible 8-15, repeating 3 pairs, then IDLE, busy=0. flash again at frame 10 -> blank restarts for 8 frames.
- flash and startOfFrame in the same cycle -> blank lasts exactly 8 subsequent ticks. enable=0 for 5 frames mid-blink -> blink resumes where it stopped.
- topLeftX changed mid-frame from 100 to 200 -> hits stay at X 100.. until the next startOfFrame. reset asserted mid-blink -> next cycle drawingRequest=0, shownCount=3, busy=0.

Source files
------------

// File: rtl/hud_pkg.sv
// Shared types and helpers for the HUD cell strip object.
package hud_pkg;

    localparam int PIX_W = 11;

    typedef enum logic [1:0] {
        BLINK_IDLE,
        BLINK_OFF,
        BLINK_ON
    } blink_state_t;

    function automatic logic [3:0] clamp_count(input logic [3:0] target, input logic [3:0] max);
        return (target > max) ? max : target;
    endfunction

endpackage

// File: rtl/hud_blink_fsm.sv
// Retriggerable blink sequencer: OFF/ON half-periods counted in frame ticks.
module hud_blink_fsm
    import hud_pkg::*;
#(
    parameter int BLINK_FRAMES  = 8,
    parameter int BLINK_REPEATS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic frameTick,
    input  logic flash,
    output logic blankN,
    output logic active
);

    localparam int HW = $clog2(BLINK_FRAMES + 1);
    localparam int RW = $clog2(BLINK_REPEATS + 1);

    blink_state_t  state, state_next;
    logic [HW-1:0] half_cnt, half_next;
    logic [RW-1:0] rep_cnt, rep_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= BLINK_IDLE;
            half_cnt <= '0;
            rep_cnt  <= '0;
        end else begin
            state    <= state_next;
            half_cnt <= half_next;
            rep_cnt  <= rep_next;
        end
    end

    // A flash takes priority over a coincident frame tick, which is then dropped.
    always_comb begin
        state_next = state;
        half_next  = half_cnt;
        rep_next   = rep_cnt;
        if (enable) begin
            if (flash) begin
                state_next = BLINK_OFF;
                half_next  = '0;
                rep_next   = '0;
            end else if (frameTick) begin
                unique case (state)
                    BLINK_OFF: begin
                        if (half_cnt == HW'(BLINK_FRAMES - 1)) begin
                            half_next  = '0;
                            state_next = BLINK_ON;
                        end else begin
                            half_next = half_cnt + 1'b1;
                        end
                    end
                    BLINK_ON: begin
                        if (half_cnt == HW'(BLINK_FRAMES - 1)) begin
                            half_next = '0;
                            if (rep_cnt == RW'(BLINK_REPEATS - 1)) begin
                                rep_next   = '0;
                                state_next = BLINK_IDLE;
                            end else begin
                                rep_next   = rep_cnt + 1'b1;
                                state_next = BLINK_OFF;
                            end
                        end else begin
                            half_next = half_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign blankN = (state != BLINK_OFF);
    assign active = (state != BLINK_IDLE);

endmodule

// File: rtl/hud_cell_strip.sv
// Row/column of identical HUD cells with per-frame origin latch, animated count and blink.
module hud_cell_strip
    import hud_pkg::*;
#(
    parameter int CELL_W        = 16,
    parameter int CELL_H        = 16,
    parameter int GAP           = 0,
    parameter int NUM_CELLS     = 6,
    parameter int IDX_W         = 3,
    parameter int VERTICAL      = 0,
    parameter int INIT_COUNT    = 3,
    parameter int STEP_FRAMES   = 4,
    parameter int BLINK_FRAMES  = 8,
    parameter int BLINK_REPEATS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    startOfFrame,
    input  logic signed [PIX_W-1:0] pixelX,
    input  logic signed [PIX_W-1:0] pixelY,
    input  logic signed [PIX_W-1:0] topLeftX,
    input  logic signed [PIX_W-1:0] topLeftY,
    input  logic [3:0]              targetCount,
    input  logic                    flash,
    output logic                    drawingRequest,
    output logic [IDX_W-1:0]        cellIndex,
    output logic [PIX_W-1:0]        offsetX,
    output logic [PIX_W-1:0]        offsetY,
    output logic [3:0]              shownCount,
    output logic                    busy
);

    localparam int REL_W  = PIX_W + 1;
    localparam int PITCH  = CELL_W + GAP;
    localparam int STEP_W = $clog2(STEP_FRAMES + 1);
    localparam logic signed [REL_W-1:0] CROSS_LIM = REL_W'(CELL_H);

    logic signed [PIX_W-1:0] tl_x, tl_y;
    logic [STEP_W-1:0]       step_cnt;
    logic [3:0]              tgt;
    logic                    blank_n, blink_active;

    assign tgt = clamp_count(targetCount, 4'(NUM_CELLS));

    hud_blink_fsm #(
        .BLINK_FRAMES (BLINK_FRAMES),
        .BLINK_REPEATS(BLINK_REPEATS)
    ) u_blink (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .frameTick(startOfFrame),
        .flash    (flash),
        .blankN   (blank_n),
        .active   (blink_active)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tl_x       <= '0;
            tl_y       <= '0;
            step_cnt   <= '0;
            shownCount <= 4'(INIT_COUNT);
        end else begin
            if (startOfFrame) begin
                tl_x <= topLeftX;
                tl_y <= topLeftY;
            end
            if (shownCount == tgt) begin
                step_cnt <= '0;
            end else if (enable && startOfFrame) begin
                if (step_cnt == STEP_W'(STEP_FRAMES - 1)) begin
                    step_cnt   <= '0;
                    shownCount <= (shownCount < tgt) ? shownCount + 4'd1 : shownCount - 4'd1;
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
        end
    end

    assign busy = (shownCount != tgt) || blink_active;

    // 12-bit signed differences so pixels before the origin stay negative instead of wrapping.
    logic signed [REL_W-1:0] rel_x, rel_y, rel_main, rel_cross;
    logic                    cross_ok;

    assign rel_x     = {pixelX[PIX_W-1], pixelX} - {tl_x[PIX_W-1], tl_x};
    assign rel_y     = {pixelY[PIX_W-1], pixelY} - {tl_y[PIX_W-1], tl_y};
    assign rel_main  = (VERTICAL != 0) ? rel_y : rel_x;
    assign rel_cross = (VERTICAL != 0) ? rel_x : rel_y;
    assign cross_ok  = !rel_cross[REL_W-1] && (rel_cross < CROSS_LIM);

    logic [NUM_CELLS-1:0] cell_hit;

    for (genvar k = 0; k < NUM_CELLS; k++) begin : g_cell
        localparam logic signed [REL_W-1:0] LO = REL_W'(k * PITCH);
        localparam logic signed [REL_W-1:0] HI = REL_W'(k * PITCH + CELL_W);
        assign cell_hit[k] = (4'(k) < shownCount) && (rel_main >= LO) && (rel_main < HI) && cross_ok;
    end

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [PIX_W-1:0] hit_lo, off_main;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_lo  = '0;
        for (int unsigned k = 0; k < NUM_CELLS; k++) begin
            if (cell_hit[k] && !hit) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
                hit_lo  = PIX_W'(k * PITCH);
            end
        end
    end

    assign off_main = rel_main[PIX_W-1:0] - hit_lo;

    always_ff @(posedge clk) begin
        if (reset || !enable || !hit || !blank_n) begin
            drawingRequest <= 1'b0;
            cellIndex      <= '0;
            offsetX        <= '0;
            offsetY        <= '0;
        end else begin
            drawingRequest <= 1'b1;
            cellIndex      <= hit_idx;
            offsetX        <= (VERTICAL != 0) ? rel_cross[PIX_W-1:0] : off_main;
            offsetY        <= (VERTICAL != 0) ? off_main : rel_cross[PIX_W-1:0];
        end
    end

endmodule
